player_shot: RTL and testbench
==============================

Name: player_shot

Overview:
- Owns the player's single upward laser shot, the counterpart of the invaders' downward missiles.
- Detects a fire-button press and launches the shot from the cannon centre on the next frame tick.
- Moves the shot up by a fixed step each frame and ends it on an invader/shield hit or at the top of the play field.
- Sequences a short explosion and cooldown before another shot is allowed. Feeds the renderer and the invader-collision/score logic.

Parameters:
- SHOT_START_Y, 440, y coordinate at launch (just above cannon).
- SHOT_STEP, 8, pixels moved up per frame.
- SHOT_MIN_Y, 8, topmost legal y; a move below this is a miss.
- PLAYER_WIDTH, 32, scaled cannon width; launch x = player_x + PLAYER_WIDTH/2.
- EXPLODE_FRAMES, 4, frames the explosion is shown after a hit (>=1).
- COOLDOWN_FRAMES, 2, frames after explosion/miss before re-arm (0 allowed).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame  in  1  one-cycle pulse per video frame
- fire  in  1  fire button, already synchronised/debounced, level
- player_x  in  10  cannon left x
- invader_hit  in  1  shot overlaps a live invader (level, from collision logic)
- shield_hit  in  1  shot overlaps a shield pixel
- shot_x  out  10  shot x (valid when shot_active or explode)
- shot_y  out  10  shot y
- shot_active  out  1  shot in flight, draw projectile
- explode  out  1  draw explosion at shot_x/shot_y
- score_pulse  out  1  one-cycle pulse when an invader hit is accepted

Behaviour:
- One clock; reset is synchronous and active-high. All state updates only on posedge clk.
- rst: state=IDLE; shot_x=0, shot_y=0, shot_active=0, explode=0, score_pulse=0, pending=0, counter=0; fire_q=1, so a button held through reset does not fire.
- Edge detect: fire_q <= fire every cycle. press = fire & ~fire_q.
- IDLE:
  - press sets pending.
  - On frame with pending (or press in that same cycle): shot_x = player_x + PLAYER_WIDTH/2 (10-bit wrap), shot_y = SHOT_START_Y, shot_active=1, pending=0, go FLIGHT.
  - Launch latency: registered outputs valid the cycle after that frame.
- FLIGHT:
  - Presses ignored and not queued.
  - Priority 1, hit in any cycle, including a frame cycle: invader_hit or shield_hit.
    - shot_active=0, explode=1, counter=EXPLODE_FRAMES, go EXPLODE, shot_y unchanged.
    - score_pulse=1 for exactly one cycle if invader_hit, even if shield_hit is also set.
  - Priority 2, frame with no hit:
    - If shot_y < SHOT_MIN_Y + SHOT_STEP (miss): shot_active=0, go COOLDOWN with counter=COOLDOWN_FRAMES, or straight to IDLE if COOLDOWN_FRAMES=0. No explode, no score.
    - Otherwise shot_y -= SHOT_STEP.
  - Compare is unsigned 11-bit, so no underflow.
- EXPLODE:
  - hit inputs ignored; shot_x/shot_y held.
  - On frame: counter -= 1. When counter==1 on a frame: explode=0, go COOLDOWN (or IDLE if COOLDOWN_FRAMES=0).
  - Explosion is therefore visible for exactly EXPLODE_FRAMES frame ticks.
- COOLDOWN:
  - On frame: counter -= 1. When counter==1 on a frame, go IDLE.
  - Presses during COOLDOWN are ignored; pending stays 0.
- player_x is sampled only at launch; cannon motion does not drag the shot.
- rst asserted mid-flight or mid-explosion: immediate return to reset values on that edge.
- score_pulse is 0 in all other cycles.

Test Plan:
- Reset with fire held high, release, pulse frame -> no launch; shot_active=0, state IDLE.
- player_x=100, fire press, then frame -> next cycle shot_active=1, shot_x=116, shot_y=440; after 3 more frames shot_y=416.
- Fire, no hits, 55 frames -> frames 1..54 move y 440→8; 55th frame miss: shot_active=0, explode=0, no score_pulse; re-fire blocked for 2 frames, launch on the first frame after that with a fresh press.
- In flight at y=200, invader_hit=1 coincident with frame -> shot_y stays 200, shot_active=0, explode=1, score_pulse high one cycle; explode drops after 4th frame; then 2 cooldown frames.
- invader_hit and shield_hit together -> single score_pulse; shield_hit alone -> explode=1 with score_pulse=0.
- Repeated fire presses during FLIGHT/EXPLODE/COOLDOWN -> no second shot; assert rst while explode=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/player_shot_if.sv
// rtl/player_shot_if.sv - frame, fire and hit inputs plus shot position/status outputs of the player shot
interface player_shot_if;
  logic       frame;
  logic       fire;
  logic [9:0] player_x;
  logic       invader_hit;
  logic       shield_hit;
  logic [9:0] shot_x;
  logic [9:0] shot_y;
  logic       shot_active;
  logic       explode;
  logic       score_pulse;

  modport master (
    input  frame, fire, player_x, invader_hit, shield_hit,
    output shot_x, shot_y, shot_active, explode, score_pulse
  );

  modport slave (
    output frame, fire, player_x, invader_hit, shield_hit,
    input  shot_x, shot_y, shot_active, explode, score_pulse
  );
endinterface

// File: rtl/player_shot.sv
// rtl/player_shot.sv - player's single upward laser shot: launch, flight, explosion and cooldown
module player_shot #(
  parameter int SHOT_START_Y    = 440,
  parameter int SHOT_STEP       = 8,
  parameter int SHOT_MIN_Y      = 8,
  parameter int PLAYER_WIDTH    = 32,
  parameter int EXPLODE_FRAMES  = 4,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst,
  player_shot_if.master bus
);

  typedef enum logic [1:0] {IDLE, FLIGHT, EXPLODE, COOLDOWN} state_t;

  localparam logic [10:0] MISS_LIMIT = 11'(SHOT_MIN_Y + SHOT_STEP);

  state_t     state;
  logic       fire_q;
  logic       pending;
  logic [7:0] counter;
  logic       press;

  assign press = bus.fire & ~fire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      fire_q          <= 1'b1;
      pending         <= 1'b0;
      counter         <= 8'd0;
      bus.shot_x      <= 10'd0;
      bus.shot_y      <= 10'd0;
      bus.shot_active <= 1'b0;
      bus.explode     <= 1'b0;
      bus.score_pulse <= 1'b0;
    end else begin
      fire_q          <= bus.fire;
      bus.score_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame && (pending || press)) begin
            bus.shot_x      <= bus.player_x + 10'(PLAYER_WIDTH / 2);
            bus.shot_y      <= 10'(SHOT_START_Y);
            bus.shot_active <= 1'b1;
            pending         <= 1'b0;
            state           <= FLIGHT;
          end else if (press) begin
            pending <= 1'b1;
          end
        end
        FLIGHT: begin
          // A hit outranks the frame move, so the explosion sits where the overlap was seen.
          if (bus.invader_hit || bus.shield_hit) begin
            bus.shot_active <= 1'b0;
            bus.explode     <= 1'b1;
            bus.score_pulse <= bus.invader_hit;
            counter         <= 8'(EXPLODE_FRAMES);
            state           <= EXPLODE;
          end else if (bus.frame) begin
            if ({1'b0, bus.shot_y} < MISS_LIMIT) begin
              bus.shot_active <= 1'b0;
              counter         <= 8'(COOLDOWN_FRAMES);
              state           <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
            end else begin
              bus.shot_y <= bus.shot_y - 10'(SHOT_STEP);
            end
          end
        end
        EXPLODE: begin
          if (bus.frame) begin
            counter <= counter - 8'd1;
            if (counter == 8'd1) begin
              bus.explode <= 1'b0;
              counter     <= 8'(COOLDOWN_FRAMES);
              state       <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (bus.frame) begin
            counter <= counter - 8'd1;
            if (counter == 8'd1) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_shot.sv
// tb/tb_player_shot.sv - directed bench for player_shot with a frame-level reference model
module tb_player_shot;

  localparam int SHOT_START_Y    = 440;
  localparam int SHOT_STEP       = 8;
  localparam int SHOT_MIN_Y      = 8;
  localparam int PLAYER_WIDTH    = 32;
  localparam int EXPLODE_FRAMES  = 4;
  localparam int COOLDOWN_FRAMES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  player_shot_if bus();

  always #5 clk = ~clk;

  player_shot #(
    .SHOT_START_Y(SHOT_START_Y), .SHOT_STEP(SHOT_STEP), .SHOT_MIN_Y(SHOT_MIN_Y),
    .PLAYER_WIDTH(PLAYER_WIDTH), .EXPLODE_FRAMES(EXPLODE_FRAMES), .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shot position in plain integers, phase given by frames still to wait.
  int m_x = 0, m_y = 0, m_expl_left = 0, m_cool_left = 0;
  bit m_act = 0, m_exp = 0, m_score = 0, m_pend = 0, m_prev_fire = 1;

  task automatic model_step();
    bit press;
    press = bus.fire && !m_prev_fire;
    m_prev_fire = bus.fire;
    m_score = 0;
    if (rst) begin
      m_x = 0; m_y = 0; m_act = 0; m_exp = 0; m_pend = 0; m_prev_fire = 1;
      m_expl_left = 0; m_cool_left = 0;
    end else if (m_act) begin
      if (bus.invader_hit || bus.shield_hit) begin
        m_act = 0; m_exp = 1; m_expl_left = EXPLODE_FRAMES; m_score = bus.invader_hit;
      end else if (bus.frame) begin
        if (m_y - SHOT_STEP < SHOT_MIN_Y) begin
          m_act = 0; m_cool_left = COOLDOWN_FRAMES;
        end else begin
          m_y = m_y - SHOT_STEP;
        end
      end
    end else if (m_exp) begin
      if (bus.frame) begin
        m_expl_left--;
        if (m_expl_left == 0) begin
          m_exp = 0; m_cool_left = COOLDOWN_FRAMES;
        end
      end
    end else if (m_cool_left > 0) begin
      if (bus.frame) m_cool_left--;
    end else begin
      if (bus.frame && (m_pend || press)) begin
        m_x = (int'(bus.player_x) + PLAYER_WIDTH / 2) % 1024;
        m_y = SHOT_START_Y; m_act = 1; m_pend = 0;
      end else if (press) begin
        m_pend = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_shot_active", int'(bus.shot_active), int'(m_act));
      check("cyc_explode", int'(bus.explode), int'(m_exp));
      check("cyc_score_pulse", int'(bus.score_pulse), int'(m_score));
      check("cyc_shot_x", int'(bus.shot_x), m_x);
      check("cyc_shot_y", int'(bus.shot_y), m_y);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_frame();
    bus.frame = 1'b1;
    cyc(1);
    bus.frame = 1'b0;
    cyc(1);
  endtask

  task automatic do_press();
    bus.fire = 1'b1;
    cyc(1);
    bus.fire = 1'b0;
    cyc(1);
  endtask

  task automatic launch_now();
    bus.frame = 1'b1;
    cyc(1);
    bus.frame = 1'b0;
  endtask

  initial begin
    bus.frame = 1'b0; bus.fire = 1'b1; bus.player_x = 10'd0;
    bus.invader_hit = 1'b0; bus.shield_hit = 1'b0;
    rst = 1'b1;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("reset_active", int'(bus.shot_active), 0);
    check("reset_xy", int'(bus.shot_x) + int'(bus.shot_y), 0);
    bus.fire = 1'b0;
    cyc(1);
    do_frame();
    check("held_fire_no_launch", int'(bus.shot_active), 0);

    bus.player_x = 10'd100;
    do_press();
    launch_now();
    check("launch_active", int'(bus.shot_active), 1);
    check("launch_x", int'(bus.shot_x), 116);
    check("launch_y", int'(bus.shot_y), 440);
    cyc(1);
    repeat (3) do_frame();
    check("three_frames_y", int'(bus.shot_y), 416);
    bus.player_x = 10'd300;
    do_frame();
    check("x_not_dragged", int'(bus.shot_x), 116);
    do_press();
    repeat (50) do_frame();
    check("top_y", int'(bus.shot_y), 8);
    check("top_still_active", int'(bus.shot_active), 1);
    do_frame();
    check("miss_inactive", int'(bus.shot_active), 0);
    check("miss_no_explode", int'(bus.explode), 0);

    do_press();
    do_frame();
    do_press();
    do_frame();
    check("cooldown_blocks", int'(bus.shot_active), 0);
    do_press();
    launch_now();
    check("relaunch_active", int'(bus.shot_active), 1);
    check("relaunch_x", int'(bus.shot_x), 316);
    cyc(1);

    repeat (30) do_frame();
    check("y_at_200", int'(bus.shot_y), 200);
    do_press();
    bus.frame = 1'b1; bus.invader_hit = 1'b1;
    cyc(1);
    check("hit_y_held", int'(bus.shot_y), 200);
    check("hit_explode", int'(bus.explode), 1);
    check("hit_score", int'(bus.score_pulse), 1);
    bus.frame = 1'b0; bus.invader_hit = 1'b0;
    cyc(1);
    check("score_one_cycle", int'(bus.score_pulse), 0);
    do_press();
    repeat (3) do_frame();
    check("explode_after_3", int'(bus.explode), 1);
    do_frame();
    check("explode_after_4", int'(bus.explode), 0);
    do_press();
    repeat (2) do_frame();
    do_frame();
    check("no_queued_shot", int'(bus.shot_active), 0);

    do_press();
    launch_now();
    cyc(1);
    bus.invader_hit = 1'b1; bus.shield_hit = 1'b1;
    cyc(1);
    check("both_hits_score", int'(bus.score_pulse), 1);
    cyc(1);
    check("both_hits_single", int'(bus.score_pulse), 0);
    bus.invader_hit = 1'b0; bus.shield_hit = 1'b0;
    repeat (6) do_frame();
    do_press();
    launch_now();
    cyc(1);
    bus.shield_hit = 1'b1;
    cyc(1);
    check("shield_explode", int'(bus.explode), 1);
    check("shield_no_score", int'(bus.score_pulse), 0);
    bus.shield_hit = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("rst_explode", int'(bus.explode), 0);
    check("rst_outputs", int'(bus.shot_x) + int'(bus.shot_y) + int'(bus.shot_active), 0);
    rst = 1'b0;
    cyc(3);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
